// File: rtl/rom_stream_reader.sv
// rom_stream_reader: read-side master for a synchronous ROM.
// Reads a run of consecutive words and streams them out through a small
// valid/ready FIFO. Issue is throttled so that a slot is always reserved
// for every word still in flight from the ROM.
module rom_stream_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [4:0]        len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [4:0]        issue_cnt;
  logic              inflight;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic push;
  logic pop;
  logic room;
  logic drained;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue throttle and stream handshake, decoded from registers only
  always_comb begin
    room      = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(FIFO_DEPTH);
    rom_en    = (state == S_RUN) && (issue_cnt != 5'd0) && room;
    rom_addr  = addr_cnt;
    push      = inflight;
    out_valid = (fifo_count != '0);
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem[rd_ptr] : '0;
    drained   = (issue_cnt == 5'd0) && !inflight &&
                ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
  end

  // Control FSM: command accept, address/issue counters, completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= rom_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_cnt  <= start_addr;
            issue_cnt <= len;
            busy      <= 1'b1;
            if (len == 5'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (rom_en) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            issue_cnt <= issue_cnt - 5'd1;
          end
          if (drained) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage: captures the ROM word one cycle after its read was issued
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rom_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
